// File: rtl/alu_arbiter.sv
// rtl/alu_arbiter.sv - two-requester round-robin front end for a shared external ALU
//
// Ports:
//   clk, rst                      clock, synchronous active-high reset
//   reqN_valid/ready/op/a/b       requester N handshake, ALU control code, operands
//   alu_in1, alu_in2, alu_ctrl    operands/control to the shared ALU (zero outside EXEC)
//   alu_out, alu_flag             ALU result and {N,C,Z} flags
//   rsp_valid/ready/id/data       registered response and owning requester
//   ccr                           condition code register {N,C,Z}
//   busy                          high whenever the FSM is not idle
`timescale 1ns/1ps
module alu_arbiter #(
  parameter int DATA_W = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req0_valid,
  output logic              req0_ready,
  input  logic [3:0]        req0_op,
  input  logic [DATA_W-1:0] req0_a,
  input  logic [DATA_W-1:0] req0_b,
  input  logic              req1_valid,
  output logic              req1_ready,
  input  logic [3:0]        req1_op,
  input  logic [DATA_W-1:0] req1_a,
  input  logic [DATA_W-1:0] req1_b,
  output logic [DATA_W-1:0] alu_in1,
  output logic [DATA_W-1:0] alu_in2,
  output logic [3:0]        alu_ctrl,
  input  logic [DATA_W-1:0] alu_out,
  input  logic [2:0]        alu_flag,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic              rsp_id,
  output logic [DATA_W-1:0] rsp_data,
  output logic [2:0]        ccr,
  output logic              busy
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_EXEC = 2'd1,
    S_RESP = 2'd2
  } state_t;

  state_t            r_state;
  logic              r_last;       // requester granted most recently
  logic              r_id;
  logic              r_rsp_valid;
  logic              r_busy;
  logic [3:0]        r_ctrl;
  logic [DATA_W-1:0] r_in1;
  logic [DATA_W-1:0] r_in2;
  logic [DATA_W-1:0] r_data;
  logic [2:0]        r_ccr;

  logic              w_any;
  logic              w_gnt_id;
  logic              w_accept;
  logic [DATA_W-1:0] w_res_data;
  logic [2:0]        w_res_ccr;

  // On a tie the requester that did not win last time gets the grant.
  assign w_any    = req0_valid | req1_valid;
  assign w_gnt_id = (req0_valid && req1_valid) ? ~r_last : req1_valid;
  assign w_accept = !rst && (r_state == S_IDLE) && w_any;

  assign req0_ready = w_accept && !w_gnt_id;
  assign req1_ready = w_accept && w_gnt_id;

  // The operand/control registers are loaded at accept and cleared when
  // EXEC ends, so the ALU bus is only non-zero for the one EXEC cycle.
  assign alu_in1   = r_in1;
  assign alu_in2   = r_in2;
  assign alu_ctrl  = r_ctrl;
  assign rsp_valid = r_rsp_valid;
  assign rsp_id    = r_id;
  assign rsp_data  = r_data;
  assign ccr       = r_ccr;
  assign busy      = r_busy;

  // Result/flag selection by op class. Carry-free ops keep C from ccr,
  // never from alu_flag[1].
  always_comb begin
    w_res_data = '0;
    w_res_ccr  = r_ccr;
    case (r_ctrl)
      4'b0010, 4'b0100, 4'b0111, 4'b1000, 4'b1011, 4'b1100: begin
        w_res_data = alu_out;
        w_res_ccr  = alu_flag;
      end
      4'b0001, 4'b0011, 4'b0101, 4'b0110: begin
        w_res_data = alu_out;
        w_res_ccr  = {alu_flag[2], r_ccr[1], alu_flag[0]};
      end
      4'b1001: w_res_ccr = {r_ccr[2], 1'b1, r_ccr[0]};
      4'b1010: w_res_ccr = {r_ccr[2], 1'b0, r_ccr[0]};
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= S_IDLE;
      r_last      <= 1'b1;
      r_id        <= 1'b0;
      r_rsp_valid <= 1'b0;
      r_busy      <= 1'b0;
      r_ctrl      <= 4'b0000;
      r_in1       <= '0;
      r_in2       <= '0;
      r_data      <= '0;
      r_ccr       <= 3'b000;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_accept) begin
            r_id   <= w_gnt_id;
            r_ctrl <= w_gnt_id ? req1_op : req0_op;
            r_in1  <= w_gnt_id ? req1_a  : req0_a;
            r_in2  <= w_gnt_id ? req1_b  : req0_b;
            r_busy <= 1'b1;
            r_state <= S_EXEC;
          end
        end
        S_EXEC: begin
          r_data      <= w_res_data;
          r_ccr       <= w_res_ccr;
          r_ctrl      <= 4'b0000;
          r_in1       <= '0;
          r_in2       <= '0;
          r_rsp_valid <= 1'b1;
          r_state     <= S_RESP;
        end
        S_RESP: begin
          if (rsp_ready) begin
            r_rsp_valid <= 1'b0;
            r_busy      <= 1'b0;
            r_last      <= r_id;
            r_state     <= S_IDLE;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_arbiter.sv
// tb/tb_alu_arbiter.sv - scoreboard bench for alu_arbiter with a behavioural shared ALU
`timescale 1ns/1ps
module tb_alu_arbiter;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req0_valid = 1'b0, req1_valid = 1'b0;
  logic        req0_ready, req1_ready;
  logic [3:0]  req0_op = 4'h0, req1_op = 4'h0;
  logic [15:0] req0_a = 16'h0, req0_b = 16'h0, req1_a = 16'h0, req1_b = 16'h0;
  logic [15:0] alu_in1, alu_in2, alu_out;
  logic [3:0]  alu_ctrl;
  logic [2:0]  alu_flag;
  logic        rsp_valid, rsp_id, busy;
  logic        rsp_ready = 1'b0;
  logic [15:0] rsp_data;
  logic [2:0]  ccr;

  alu_arbiter #(.DATA_W(16)) dut (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_op(req0_op), .req0_a(req0_a), .req0_b(req0_b),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_op(req1_op), .req1_a(req1_a), .req1_b(req1_b),
    .alu_in1(alu_in1), .alu_in2(alu_in2), .alu_ctrl(alu_ctrl), .alu_out(alu_out), .alu_flag(alu_flag),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_id(rsp_id), .rsp_data(rsp_data),
    .ccr(ccr), .busy(busy)
  );

  always #5 clk = ~clk;

  // Stand-in ALU: {N,C,Z,out}. AND reports C=0 so a design that wrongly
  // takes C from alu_flag for carry-free ops is visible.
  function automatic logic [18:0] alu_model(input logic [3:0] c, input logic [15:0] a, input logic [15:0] b);
    logic [16:0] s;
    logic [15:0] o;
    logic        cy;
    case (c)
      4'b0010: begin s = {1'b0, a} + {1'b0, b}; o = s[15:0]; cy = s[16]; end
      4'b0100: begin o = a - b; cy = (a < b); end
      4'b0101: begin o = a & b; cy = 1'b0; end
      4'b0001: begin o = a + 16'd1; cy = (a == 16'hFFFF); end
      default: begin o = a ^ {b[7:0], b[15:8]} ^ {12'h000, c}; cy = a[3] ^ b[5]; end
    endcase
    return {o[15], cy, (o == 16'h0000), o};
  endfunction

  assign {alu_flag, alu_out} = alu_model(alu_ctrl, alu_in1, alu_in2);

  // Reference: {new ccr, rsp_data} from the op-class rules.
  function automatic logic [18:0] expect_rsp(input logic [3:0] op, input logic [15:0] a, input logic [15:0] b, input logic [2:0] c);
    logic [18:0] f;
    f = alu_model(op, a, b);
    if (op inside {4'h2, 4'h4, 4'h7, 4'h8, 4'hB, 4'hC}) return f;
    if (op inside {4'h1, 4'h3, 4'h5, 4'h6}) return {f[18], c[1], f[16], f[15:0]};
    if (op == 4'h9) return {c[2], 1'b1, c[0], 16'h0000};
    if (op == 4'hA) return {c[2], 1'b0, c[0], 16'h0000};
    return {c, 16'h0000};
  endfunction

  int n_tot = 0;
  int n_bad = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tot++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  // Model state (high level: one op in flight, age in cycles since grant)
  logic        m_busy = 1'b0;
  int          m_age = 0;
  logic        m_last = 1'b1;
  logic        m_id = 1'b0;
  logic [2:0]  m_ccr = 3'b000;
  logic [3:0]  m_op;
  logic [15:0] m_a, m_b;
  logic        acc0 = 1'b0, acc1 = 1'b0;
  logic [19:0] sb[$];
  logic        glog[$];
  logic [19:0] rlog[$];
  int          valid_cycles = 0;

  // Grant / sequencing model
  always @(negedge clk) begin
    logic        g_any, g_id;
    logic [18:0] e;
    if (rst) begin
      chk("ready0_in_rst", req0_ready, 1'b0);
      chk("ready1_in_rst", req1_ready, 1'b0);
      m_busy = 1'b0; m_age = 0; m_last = 1'b1; m_ccr = 3'b000;
      sb.delete(); acc0 = 1'b0; acc1 = 1'b0;
    end else if (!m_busy) begin
      g_any = req0_valid | req1_valid;
      if (req0_valid && req1_valid) g_id = !m_last;
      else                          g_id = req1_valid;
      chk("ready0", req0_ready, g_any && !g_id);
      chk("ready1", req1_ready, g_any && g_id);
      chk("idle_busy", busy, 1'b0);
      chk("idle_rsp_valid", rsp_valid, 1'b0);
      chk("idle_alu_bus", {alu_ctrl, alu_in1, alu_in2}, 36'h0);
      chk("idle_ccr", ccr, m_ccr);
      if (g_any) begin
        m_id = g_id;
        m_op = g_id ? req1_op : req0_op;
        m_a  = g_id ? req1_a  : req0_a;
        m_b  = g_id ? req1_b  : req0_b;
        e = expect_rsp(m_op, m_a, m_b, m_ccr);
        m_ccr = e[18:16];
        sb.push_back({m_id, e});
        glog.push_back(m_id);
        m_busy = 1'b1; m_age = 0;
        if (g_id) acc1 = 1'b1; else acc0 = 1'b1;
      end
    end else begin
      m_age++;
      chk("busy_ready0", req0_ready, 1'b0);
      chk("busy_ready1", req1_ready, 1'b0);
      chk("busy_flag", busy, 1'b1);
      if (m_age == 1) begin
        chk("exec_alu_bus", {alu_ctrl, alu_in1, alu_in2}, {m_op, m_a, m_b});
        chk("exec_rsp_valid", rsp_valid, 1'b0);
      end else begin
        chk("resp_rsp_valid", rsp_valid, 1'b1);
        chk("resp_alu_bus", {alu_ctrl, alu_in1, alu_in2}, 36'h0);
        if (rsp_ready) begin m_busy = 1'b0; m_last = m_id; end
      end
    end
  end

  // Response monitor / scoreboard
  always @(negedge clk) begin
    if (!rst && rsp_valid) begin
      valid_cycles++;
      if (sb.size() == 0) begin
        chk("unexpected_rsp", {rsp_id, ccr, rsp_data}, 20'h0);
        n_bad += (rsp_valid ? 0 : 1);
      end else begin
        chk("rsp", {rsp_id, ccr, rsp_data}, sb[0]);
        if (rsp_ready) rlog.push_back(sb.pop_front());
      end
    end
  end

  task automatic do_reset();
    @(posedge clk); #1;
    rst = 1'b1; req0_valid = 1'b1; req1_valid = 1'b1; rsp_ready = 1'b1;
    req0_op = 4'h2; req1_op = 4'h4;
    repeat (3) begin @(posedge clk); #1; end
    rst = 1'b0; req0_valid = 1'b0; req1_valid = 1'b0; acc0 = 1'b0; acc1 = 1'b0;
  endtask

  task automatic drop_accepted();
    if (acc0) begin req0_valid = 1'b0; acc0 = 1'b0; end
    if (acc1) begin req1_valid = 1'b0; acc1 = 1'b0; end
  endtask

  task automatic drain(input string name);
    int n;
    n = 0;
    while (n < 300) begin
      @(posedge clk); #1;
      drop_accepted();
      if (!req0_valid && !req1_valid && !m_busy) break;
      n++;
    end
    chk(name, (n < 300), 1'b1);
  endtask

  task automatic run_pair(input logic v0, input logic [3:0] o0, input logic [15:0] a0, input logic [15:0] b0,
                          input logic v1, input logic [3:0] o1, input logic [15:0] a1, input logic [15:0] b1);
    @(posedge clk); #1;
    req0_valid = v0; req0_op = o0; req0_a = a0; req0_b = b0;
    req1_valid = v1; req1_op = o1; req1_a = a1; req1_b = b1;
    rsp_ready = 1'b1;
    drain("pair_done");
  endtask

  function automatic logic [15:0] rnd_operand();
    logic [15:0] v;
    case ($urandom_range(0, 7))
      0: v = 16'hFFFF;
      1: v = 16'h0000;
      2: v = 16'h7FFF;
      default: v = 16'($urandom);
    endcase
    return v;
  endfunction

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    do_reset();
    @(negedge clk);
    chk("reset_state", {rsp_valid, busy, rsp_id, ccr, rsp_data}, 22'h0);

    // Tie after reset: req0 first, then req1.
    rlog.delete();
    run_pair(1'b1, 4'b0010, 16'h7FFF, 16'h0001, 1'b1, 4'b0100, 16'h0005, 16'h0005);
    chk("tie_first", rlog[0], {1'b0, 3'b100, 16'h8000});
    chk("tie_second", rlog[1], {1'b1, 3'b001, 16'h0000});

    // SEC then AND: C survives the carry-free op.
    rlog.delete();
    run_pair(1'b1, 4'b1001, 16'h1111, 16'h2222, 1'b0, 4'h0, 16'h0, 16'h0);
    run_pair(1'b0, 4'h0, 16'h0, 16'h0, 1'b1, 4'b0101, 16'h00F0, 16'h000F);
    chk("sec_rsp", rlog[0], {1'b0, 3'b011, 16'h0000});
    chk("and_keeps_c", rlog[1], {1'b1, 3'b011, 16'h0000});

    // Op 1111: zero data, ccr untouched.
    rlog.delete();
    run_pair(1'b1, 4'b1111, 16'h1234, 16'h5678, 1'b0, 4'h0, 16'h0, 16'h0);
    chk("op_f_rsp", rlog[0], {1'b0, 3'b011, 16'h0000});

    // Back-pressure: accept at T, rsp_ready low T+2..T+5.
    @(posedge clk); #1;
    req0_valid = 1'b1; req0_op = 4'b0111; req0_a = 16'hA5A5; req0_b = 16'h0F0F; rsp_ready = 1'b0;
    n = 0;
    while (!acc0 && n < 50) begin @(posedge clk); #1; n++; end
    chk("hold_accept", (n < 50), 1'b1);
    req0_valid = 1'b0; acc0 = 1'b0; valid_cycles = 0;
    repeat (5) begin @(posedge clk); #1; end
    rsp_ready = 1'b1;
    repeat (2) begin @(posedge clk); #1; end
    chk("hold_cycles", valid_cycles, 5);

    // Both requesters held valid: grants alternate.
    do_reset();
    glog.delete();
    @(posedge clk); #1;
    req0_valid = 1'b1; req0_op = 4'b0010; req0_a = 16'h0001; req0_b = 16'h0002;
    req1_valid = 1'b1; req1_op = 4'b0100; req1_a = 16'h0009; req1_b = 16'h0003;
    rsp_ready = 1'b1;
    n = 0;
    while (n < 300) begin
      @(posedge clk); #1;
      if (acc0) begin
        acc0 = 1'b0;
        if (glog.size() >= 6) req0_valid = 1'b0;
        else begin req0_op = 4'($urandom_range(0, 15)); req0_a = rnd_operand(); req0_b = rnd_operand(); end
      end
      if (acc1) begin
        acc1 = 1'b0;
        if (glog.size() >= 6) req1_valid = 1'b0;
        else begin req1_op = 4'($urandom_range(0, 15)); req1_a = rnd_operand(); req1_b = rnd_operand(); end
      end
      if (!req0_valid && !req1_valid && !m_busy) break;
      n++;
    end
    chk("alt_done", (n < 300), 1'b1);
    for (int k = 0; k < 6; k++) chk($sformatf("alt_grant%0d", k), glog[k], k % 2);

    // Reset during EXEC of INC 0xFFFF: no response, ccr cleared.
    do_reset();
    valid_cycles = 0;
    @(posedge clk); #1;
    req0_valid = 1'b1; req0_op = 4'b0001; req0_a = 16'hFFFF; req0_b = 16'h0000; rsp_ready = 1'b1;
    n = 0;
    while (!acc0 && n < 50) begin @(posedge clk); #1; n++; end
    chk("midrst_accept", (n < 50), 1'b1);
    rst = 1'b1; req0_valid = 1'b0; acc0 = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk("midrst_state", {busy, rsp_valid, ccr}, 5'b0);
    repeat (6) @(posedge clk);
    chk("midrst_no_rsp", valid_cycles, 0);

    // Randomized traffic.
    do_reset();
    repeat (3000) begin
      @(posedge clk); #1;
      drop_accepted();
      if (!req0_valid && $urandom_range(0, 99) < 40) begin
        req0_valid = 1'b1; req0_op = 4'($urandom_range(0, 15)); req0_a = rnd_operand(); req0_b = rnd_operand();
      end
      if (!req1_valid && $urandom_range(0, 99) < 40) begin
        req1_valid = 1'b1; req1_op = 4'($urandom_range(0, 15)); req1_a = rnd_operand(); req1_b = rnd_operand();
      end
      rsp_ready = ($urandom_range(0, 99) < 60);
    end
    rsp_ready = 1'b1;
    drain("random_drain");
    chk("sb_empty", sb.size(), 0);

    $display("test done: total=%0d bad=%0d", n_tot, n_bad);
    $finish;
  end

endmodule

// File: doc/alu_arbiter.md
ALU_ARBITER -- requirements
Module: alu_arbiter

Interface
REQ-001 SHALL have parameter DATA_W, default 16, datapath width; only 16 is supported.
REQ-002 SHALL have port clk  input  1  single clock, all state updates on rising edge.
REQ-003 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-004 SHALL have ports req0_valid/req1_valid  input  1  requester n has an operation pending.
REQ-005 SHALL have ports req0_ready/req1_ready  output  1  requester n's operation accepted this cycle.
REQ-006 SHALL have ports req0_op/req1_op  input  4  ALU control code.
REQ-007 SHALL have ports req0_a/req1_a, req0_b/req1_b  input  16  operands in1, in2.
REQ-008 SHALL have ports alu_in1, alu_in2  output  16  operands to the shared ALU.
REQ-009 SHALL have port alu_ctrl  output  4  ALU control code to the shared ALU.
REQ-010 SHALL have port alu_out  input  16  ALU result.
REQ-011 SHALL have port alu_flag  input  3  ALU flags {N,C,Z}.
REQ-012 SHALL have port rsp_valid  output  1  result available.
REQ-013 SHALL have port rsp_ready  input  1  consumer takes the result.
REQ-014 SHALL have port rsp_id  output  1  requester index owning the result.
REQ-015 SHALL have port rsp_data  output  16  registered result.
REQ-016 SHALL have port ccr  output  3  condition code register {N,C,Z}.
REQ-017 SHALL have port busy  output  1  high whenever state is not IDLE.

Function
REQ-018 SHALL implement FSM states IDLE, EXEC, RESP.
REQ-019 IDLE: if any req valid, SHALL grant one, assert that req_ready only, latch op/a/b/id, go to EXEC; else stay.
REQ-020 Arbitration SHALL be round-robin: both valid -> grant the requester not granted last; one valid -> grant it.
REQ-021 req_ready SHALL be combinational, high only in IDLE for the granted requester, never both.
REQ-022 EXEC (one cycle): alu_in1/alu_in2/alu_ctrl SHALL be driven from latched values; at cycle end rsp_data, ccr updated; go to RESP.
REQ-023 Outside EXEC, alu_ctrl SHALL be 4'b0000 and alu_in1/alu_in2 SHALL be 0.
REQ-024 RESP: rsp_valid SHALL be high, rsp_id/rsp_data stable; on rsp_ready go to IDLE and record last grant; else hold.
REQ-025 Latency: accept in cycle T -> rsp_valid in T+2; minimum 3 cycles per op; no accept in EXEC/RESP.
REQ-026 Op codes 0010,0100,0111,1000,1011,1100: rsp_data=alu_out; ccr={N,C,Z} all from alu_flag.
REQ-027 Op codes 0001,0011,0101,0110: rsp_data=alu_out; ccr N,Z from alu_flag; C unchanged.
REQ-028 Op 1001: ccr C=1, N,Z unchanged; op 1010: ccr C=0, N,Z unchanged; rsp_data=0 for both.
REQ-029 Op 0000 and 1101-1111: rsp_data=0, ccr unchanged; response still produced.
REQ-030 C for carry-free ops SHALL come from ccr register, never from alu_flag[1].
REQ-031 New req_valid during EXEC/RESP SHALL wait; requesters hold valid/op/operands until ready.
REQ-032 rsp_ready outside RESP SHALL be ignored.

Reset
REQ-033 rst high at a clock edge SHALL force IDLE, ccr=000, rsp_data=0, rsp_id=0, rsp_valid=0, busy=0, last grant=req1 (req0 wins first tie).
REQ-034 rst mid-operation SHALL discard the in-flight op with no response and no ccr update.
REQ-035 req_ready SHALL be 0 in any cycle rst is high.

Verification
REQ-036 After reset, both valid, req0 ADD 0x7FFF+0x0001, req1 SUB 5-5 -> req0 first: rsp_id=0, rsp_data=0x8000, ccr N=1,C=0,Z=0; then req1: rsp_data=0, Z=1.
REQ-037 SEC then AND 0x00F0&0x000F -> after AND rsp_data=0, ccr=Z=1,C=1,N=0 (C preserved).
REQ-038 Accept at T with rsp_ready low for 4 cycles -> rsp_valid T+2..T+6, data stable, req_ready both 0 throughout.
REQ-039 Both requesters held valid 6 ops -> grants alternate 0,1,0,1,0,1.
REQ-040 rst asserted in EXEC of INC 0xFFFF -> next cycle IDLE, ccr=000, rsp_valid never asserted.
REQ-041 Op 1111 with a=0x1234 -> rsp_data=0, ccr unchanged, alu_ctrl=1111 only during EXEC.
